// File: rtl/kronos_mem_pkg.sv
// Shared types and constants for the kronos instruction/data memory arbiter.
package kronos_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    typedef enum logic {
        PORT_INSTR,
        PORT_DATA
    } port_t;

    localparam logic [3:0] FULL_MASK = 4'hF;

endpackage

// File: rtl/kronos_mem_watchdog.sv
// Transaction watchdog: counts cycles spent waiting on the downstream port,
// flags an abort when the limit is reached and keeps a saturating abort tally.
module kronos_mem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        ack,
    output logic        abort,
    output logic [15:0] abort_count
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CW-1:0] count_reg;
    logic [15:0]   abort_count_reg;
    logic          hit;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign hit = 1'b0;
        end else begin : g_enabled
            assign hit = (count_reg == CW'(TIMEOUT_CYCLES));
        end
    endgenerate

    // A real ack in the same cycle always takes precedence over the abort.
    assign abort       = !reset && enable && hit && !ack;
    assign abort_count = abort_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg       <= '0;
            abort_count_reg <= '0;
        end else begin
            if (clear) begin
                count_reg <= '0;
            end else if (enable && (count_reg != '1)) begin
                count_reg <= count_reg + 1'b1;
            end
            if (abort && (abort_count_reg != 16'hFFFF)) begin
                abort_count_reg <= abort_count_reg + 16'd1;
            end
        end
    end

endmodule

// File: rtl/kronos_mem_arbiter.sv
// Merges the kronos fetch and load/store ports onto one downstream memory port,
// with fixed or round-robin arbitration and a watchdog for hung transactions.
module kronos_mem_arbiter
    import kronos_mem_pkg::*;
#(
    parameter bit          ROUND_ROBIN    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter logic [31:0] ERROR_DATA     = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic        instr_ack,
    output logic [31:0] instr_data,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic        data_ack,
    output logic [31:0] data_rd_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_mask,
    output logic        mem_wr_en,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_q,
    output logic        bus_error,
    output logic [15:0] timeout_count
);

    state_t      state_reg, state_next;
    port_t       last_grant_reg, last_grant_next;
    logic [31:0] mem_addr_reg, mem_wr_data_reg;
    logic [3:0]  mem_mask_reg;
    logic        mem_wr_en_reg, mem_req_reg;
    logic        grant_instr, grant_data;
    logic        busy, abort, finish;
    logic [31:0] resp_data;

    assign busy   = (state_reg != IDLE);
    assign finish = busy && (mem_ack || abort);

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        grant_instr     = 1'b0;
        grant_data      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                // Data wins a tie unless round-robin says it had the last turn.
                if (data_req && (!instr_req || !ROUND_ROBIN || (last_grant_reg == PORT_INSTR))) begin
                    state_next      = BUSY_D;
                    last_grant_next = PORT_DATA;
                    grant_data      = 1'b1;
                end else if (instr_req) begin
                    state_next      = BUSY_I;
                    last_grant_next = PORT_INSTR;
                    grant_instr     = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack || abort) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            last_grant_reg  <= PORT_INSTR;
            mem_req_reg     <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wr_data_reg <= '0;
            mem_mask_reg    <= '0;
            mem_wr_en_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            if (grant_data) begin
                mem_req_reg     <= 1'b1;
                mem_addr_reg    <= data_addr;
                mem_wr_data_reg <= data_wr_data;
                mem_mask_reg    <= data_mask;
                mem_wr_en_reg   <= data_wr_en;
            end else if (grant_instr) begin
                mem_req_reg     <= 1'b1;
                mem_addr_reg    <= instr_addr;
                mem_wr_data_reg <= '0;
                mem_mask_reg    <= FULL_MASK;
                mem_wr_en_reg   <= 1'b0;
            end else if (finish) begin
                mem_req_reg <= 1'b0;
            end
        end
    end

    kronos_mem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .clear      (grant_instr || grant_data),
        .enable     (busy),
        .ack        (mem_ack),
        .abort      (abort),
        .abort_count(timeout_count)
    );

    // Responses are suppressed during reset so a dropped transaction never acks.
    assign resp_data    = mem_ack ? mem_q : ERROR_DATA;
    assign instr_ack    = !reset && (state_reg == BUSY_I) && (mem_ack || abort);
    assign data_ack     = !reset && (state_reg == BUSY_D) && (mem_ack || abort);
    assign instr_data   = instr_ack ? resp_data : '0;
    assign data_rd_data = data_ack ? resp_data : '0;
    assign bus_error    = abort;

    assign mem_addr    = mem_addr_reg;
    assign mem_wr_data = mem_wr_data_reg;
    assign mem_mask    = mem_mask_reg;
    assign mem_wr_en   = mem_wr_en_reg;
    assign mem_req     = mem_req_reg;

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Directed bench for kronos_mem_arbiter: a round-robin instance and a
// data-priority instance share the same stimulus, both with an 8-cycle watchdog.
module tb_kronos_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_addr = '0;
    logic        instr_req = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wr_data = '0;
    logic [3:0]  data_mask = '0;
    logic        data_wr_en = 1'b0;
    logic        data_req = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_q = '0;

    logic        instr_ack, data_ack, mem_wr_en, mem_req, bus_error;
    logic [31:0] instr_data, data_rd_data, mem_addr, mem_wr_data;
    logic [3:0]  mem_mask;
    logic [15:0] timeout_count;

    logic        instr_ack_b, data_ack_b, mem_wr_en_b, mem_req_b, bus_error_b;
    logic [31:0] instr_data_b, data_rd_data_b, mem_addr_b, mem_wr_data_b;
    logic [3:0]  mem_mask_b;
    logic [15:0] timeout_count_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kronos_mem_arbiter #(
        .ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(8), .ERROR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .reset(reset),
        .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_ack(instr_ack), .instr_data(instr_data),
        .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
        .data_wr_en(data_wr_en), .data_req(data_req),
        .data_ack(data_ack), .data_rd_data(data_rd_data),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_mask(mem_mask),
        .mem_wr_en(mem_wr_en), .mem_req(mem_req), .mem_ack(mem_ack), .mem_q(mem_q),
        .bus_error(bus_error), .timeout_count(timeout_count)
    );

    kronos_mem_arbiter #(
        .ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(8), .ERROR_DATA(32'hDEAD_BEEF)
    ) dut_fixed (
        .clk(clk), .reset(reset),
        .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_ack(instr_ack_b), .instr_data(instr_data_b),
        .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
        .data_wr_en(data_wr_en), .data_req(data_req),
        .data_ack(data_ack_b), .data_rd_data(data_rd_data_b),
        .mem_addr(mem_addr_b), .mem_wr_data(mem_wr_data_b), .mem_mask(mem_mask_b),
        .mem_wr_en(mem_wr_en_b), .mem_req(mem_req_b), .mem_ack(mem_ack), .mem_q(mem_q),
        .bus_error(bus_error_b), .timeout_count(timeout_count_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_wr_en, instr_ack, data_ack, bus_error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000", {mem_req, mem_wr_en, instr_ack, data_ack, bus_error});
        end
        checks++;
        if ({mem_addr, mem_wr_data, mem_mask, timeout_count} !== 84'h0) begin
            errors++;
            $display("FAIL reset_fields got addr=%h wdata=%h mask=%h tcount=%0d want all zero",
                     mem_addr, mem_wr_data, mem_mask, timeout_count);
        end
        $display("txn reset released");
    endtask

    task automatic test_single_fetch();
        tick();
        instr_addr = 32'h0000_0100;
        instr_req  = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, mem_wr_en, mem_mask, mem_wr_data} !== {1'b1, 32'h100, 1'b0, 4'hF, 32'h0}) begin
            errors++;
            $display("FAIL fetch_fields got req=%b addr=%h we=%b mask=%h wdata=%h want 1 00000100 0 f 00000000",
                     mem_req, mem_addr, mem_wr_en, mem_mask, mem_wr_data);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if ({instr_ack, data_ack, mem_req} !== 3'b001) begin
                errors++;
                $display("FAIL fetch_wait got iack=%b dack=%b req=%b want 0 0 1", instr_ack, data_ack, mem_req);
            end
        end
        tick();
        mem_ack = 1'b1;
        mem_q   = 32'h0000_0013;
        @(negedge clk);
        checks++;
        if ({instr_ack, instr_data} !== {1'b1, 32'h13}) begin
            errors++;
            $display("FAIL fetch_ack got ack=%b data=%h want 1 00000013", instr_ack, instr_data);
        end
        checks++;
        if ({data_ack, data_rd_data} !== 33'h0) begin
            errors++;
            $display("FAIL fetch_other got dack=%b ddata=%h want 0 00000000", data_ack, data_rd_data);
        end
        $display("txn fetch addr=%h data=%h", mem_addr, instr_data);
        tick();
        mem_ack   = 1'b0;
        instr_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, instr_ack} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_release got req=%b iack=%b want 0 0", mem_req, instr_ack);
        end
    endtask

    task automatic test_store();
        tick();
        data_addr    = 32'h0000_2004;
        data_wr_data = 32'hA5A5_A5A5;
        data_mask    = 4'b0011;
        data_wr_en   = 1'b1;
        data_req     = 1'b1;
        tick();
        mem_ack = 1'b1;
        mem_q   = 32'h0000_0055;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, mem_wr_data, mem_mask, mem_wr_en} !== {1'b1, 32'h2004, 32'hA5A5A5A5, 4'b0011, 1'b1}) begin
            errors++;
            $display("FAIL store_fields got req=%b addr=%h wdata=%h mask=%h we=%b want 1 00002004 a5a5a5a5 3 1",
                     mem_req, mem_addr, mem_wr_data, mem_mask, mem_wr_en);
        end
        checks++;
        if ({data_ack, data_rd_data, instr_ack, instr_data} !== {1'b1, 32'h55, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL store_ack got dack=%b ddata=%h iack=%b idata=%h want 1 00000055 0 00000000",
                     data_ack, data_rd_data, instr_ack, instr_data);
        end
        $display("txn store addr=%h wdata=%h mask=%h", mem_addr, mem_wr_data, mem_mask);
        tick();
        mem_ack    = 1'b0;
        data_req   = 1'b0;
        data_wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, data_ack} !== 2'b00) begin
            errors++;
            $display("FAIL store_release got req=%b dack=%b want 0 0", mem_req, data_ack);
        end
    endtask

    task automatic test_round_robin();
        logic        want_data;
        logic [31:0] want_addr;
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        instr_addr   = 32'h0000_0100;
        data_addr    = 32'h0000_2004;
        data_wr_data = 32'h0000_0000;
        data_mask    = 4'hF;
        data_wr_en   = 1'b0;
        instr_req    = 1'b1;
        data_req     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            mem_ack = 1'b1;
            mem_q   = 32'h1000 + k;
            want_data = (k % 2 == 0);
            want_addr = want_data ? 32'h2004 : 32'h100;
            @(negedge clk);
            checks++;
            if ({data_ack, instr_ack, mem_addr} !== {want_data, !want_data, want_addr}) begin
                errors++;
                $display("FAIL rr_grant%0d got dack=%b iack=%b addr=%h want %b %b %h",
                         k, data_ack, instr_ack, mem_addr, want_data, !want_data, want_addr);
            end
            checks++;
            if ({data_ack_b, instr_ack_b, mem_addr_b} !== {1'b1, 1'b0, 32'h2004}) begin
                errors++;
                $display("FAIL fixed_grant%0d got dack=%b iack=%b addr=%h want 1 0 00002004",
                         k, data_ack_b, instr_ack_b, mem_addr_b);
            end
            checks++;
            if ({data_rd_data_b, instr_data_b, bus_error_b, timeout_count_b, mem_wr_en_b, mem_mask_b, mem_wr_data_b, mem_req_b}
                !== {mem_q, 32'h0, 1'b0, 16'h0, 1'b0, 4'hF, 32'h0, 1'b1}) begin
                errors++;
                $display("FAIL fixed_fields%0d got rdata=%h idata=%h err=%b tc=%0d we=%b mask=%h wdata=%h req=%b",
                         k, data_rd_data_b, instr_data_b, bus_error_b, timeout_count_b, mem_wr_en_b,
                         mem_mask_b, mem_wr_data_b, mem_req_b);
            end
            $display("txn tie%0d rr_winner=%s fixed_winner=%s", k, data_ack ? "D" : "I", data_ack_b ? "D" : "I");
            tick();
            mem_ack = 1'b0;
            if (k == 3) begin
                instr_req = 1'b0;
                data_req  = 1'b0;
            end
        end
    endtask

    task automatic test_timeout();
        data_addr = 32'h0000_3000;
        data_req  = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({data_ack, bus_error, mem_req} !== 3'b001) begin
                errors++;
                $display("FAIL timeout_wait%0d got dack=%b err=%b req=%b want 0 0 1", i, data_ack, bus_error, mem_req);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if ({data_ack, data_rd_data, bus_error, instr_ack} !== {1'b1, 32'hDEADBEEF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL timeout_abort got dack=%b ddata=%h err=%b iack=%b want 1 deadbeef 1 0",
                     data_ack, data_rd_data, bus_error, instr_ack);
        end
        $display("txn timeout addr=%h rdata=%h", mem_addr, data_rd_data);
        data_req = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if ({mem_req, bus_error, timeout_count, timeout_count_b} !== {1'b0, 1'b0, 16'd1, 16'd1}) begin
            errors++;
            $display("FAIL timeout_after got req=%b err=%b tc=%0d tc_fixed=%0d want 0 0 1 1",
                     mem_req, bus_error, timeout_count, timeout_count_b);
        end
        tick();
        instr_addr = 32'h0000_0200;
        instr_req  = 1'b1;
        tick();
        mem_ack = 1'b1;
        mem_q   = 32'h0000_0077;
        @(negedge clk);
        checks++;
        if ({instr_ack, instr_data, bus_error, mem_addr} !== {1'b1, 32'h77, 1'b0, 32'h200}) begin
            errors++;
            $display("FAIL post_timeout_fetch got ack=%b data=%h err=%b addr=%h want 1 00000077 0 00000200",
                     instr_ack, instr_data, bus_error, mem_addr);
        end
        $display("txn fetch addr=%h data=%h", mem_addr, instr_data);
        tick();
        mem_ack   = 1'b0;
        instr_req = 1'b0;
    endtask

    task automatic test_ack_at_timeout();
        tick();
        data_addr = 32'h0000_3004;
        data_req  = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        mem_ack = 1'b1;
        mem_q   = 32'h0000_1234;
        @(negedge clk);
        checks++;
        if ({data_ack, data_rd_data, bus_error} !== {1'b1, 32'h1234, 1'b0}) begin
            errors++;
            $display("FAIL ack_vs_timeout got dack=%b ddata=%h err=%b want 1 00001234 0",
                     data_ack, data_rd_data, bus_error);
        end
        $display("txn load addr=%h rdata=%h", mem_addr, data_rd_data);
        tick();
        mem_ack  = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, timeout_count} !== {1'b0, 16'd1}) begin
            errors++;
            $display("FAIL ack_vs_timeout_count got req=%b tc=%0d want 0 1", mem_req, timeout_count);
        end
    endtask

    task automatic test_reset_busy();
        tick();
        instr_addr = 32'h0000_0400;
        instr_req  = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_req got %b want 1", mem_req);
        end
        tick();
        reset     = 1'b1;
        instr_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({instr_ack, data_ack} !== 2'b00) begin
            errors++;
            $display("FAIL rst_busy_ack got iack=%b dack=%b want 0 0", instr_ack, data_ack);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_drop got req=%b want 0", mem_req);
        end
        tick();
        mem_ack = 1'b1;
        mem_q   = 32'h0000_0099;
        @(negedge clk);
        checks++;
        if ({instr_ack, instr_data, data_ack, data_rd_data} !== 66'h0) begin
            errors++;
            $display("FAIL spurious_ack got iack=%b idata=%h dack=%b ddata=%h want all zero",
                     instr_ack, instr_data, data_ack, data_rd_data);
        end
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle got req=%b want 0", mem_req);
        end
        $display("txn reset_in_busy dropped");
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_round_robin();
        test_timeout();
        test_ack_at_timeout();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/kronos_mem_arbiter.md
Name: kronos_mem_arbiter

Overview:
Shares one memory_map-style memory port between the kronos_core instruction fetch port and its load/store port. Sits between the core and a single-ported memory/bridge, for when instruction and data storage are merged (e.g. SDRAM or an external bus). It arbitrates with a fixed or round-robin policy, latches the winning request and forwards the one-cycle ack and read data back to the winner. A watchdog aborts hung transactions.

Parameters:
ROUND_ROBIN, 1, 1 = alternate grants on simultaneous requests; 0 = data port always wins.
TIMEOUT_CYCLES, 1023, cycles in BUSY without downstream ack before abort; 0 disables the watchdog.
ERROR_DATA, 32'hDEAD_BEEF, read data returned on an aborted transaction.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
instr_addr  in  32  fetch address
instr_req  in  1  fetch request, held until instr_ack
instr_ack  out  1  one-cycle fetch completion
instr_data  out  32  fetch data, valid when instr_ack
data_addr  in  32  load/store address
data_wr_data  in  32  store data
data_mask  in  4  byte enables
data_wr_en  in  1  1 = store
data_req  in  1  load/store request, held until data_ack
data_ack  out  1  one-cycle load/store completion
data_rd_data  out  32  load data, valid when data_ack
mem_addr  out  32  downstream address (registered)
mem_wr_data  out  32  downstream store data (registered)
mem_mask  out  4  downstream byte enables (registered)
mem_wr_en  out  1  downstream write enable (registered)
mem_req  out  1  downstream request (registered)
mem_ack  in  1  downstream one-cycle completion
mem_q  in  32  downstream read data, valid when mem_ack
bus_error  out  1  one-cycle pulse with the aborting ack
timeout_count  out  16  saturating count of watchdog aborts

Behaviour:
- Reset: FSM to IDLE. mem_req, mem_wr_en, instr_ack, data_ack and bus_error = 0. mem_addr, mem_wr_data and timeout_count = 0. mem_mask = 0. last_grant = INSTR, so data wins the first tie.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE: a request seen in cycle N moves the FSM to BUSY_x and raises mem_req in cycle N+1. Address, data, mask and wr_en are latched at the same edge.
- Instruction grant drives mem_wr_en=0, mem_mask=4'hF, mem_wr_data=0.
- Tie (both req high in IDLE): data wins if ROUND_ROBIN=0. Otherwise the port not equal to last_grant wins. last_grant updates on every grant.
- BUSY_x: mem_req is held high and the latched fields stay stable. Requester inputs are ignored.
- On mem_ack: the winner's ack goes high combinationally in the same cycle. mem_q is routed combinationally to the winner's read-data output. mem_req drops at the next edge and the FSM returns to IDLE.
- Minimum transaction: 2 cycles (req to mem_req is registered). The requester may keep req high after its ack; that is a new request, re-arbitrated in IDLE the following cycle.
- Only one ack per cycle. The non-winner's ack is 0 and its read data is 0.
- Watchdog counter clears on grant and increments in BUSY. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES without mem_ack:
  - winner's ack=1, read data=ERROR_DATA, bus_error=1 for one cycle;
  - mem_req drops and the FSM returns to IDLE;
  - timeout_count increments, saturating at 16'hFFFF.
- mem_ack and timeout in the same cycle: mem_ack wins, normal completion, no error.
- mem_ack while IDLE (spurious or late): ignored, no ack forwarded.
- Reset mid-transaction: the transaction is dropped at once, with no ack to either requester. mem_req = 0 next cycle.

Decomposition:
- Package kronos_mem_pkg:
  - typedef state_t {IDLE, BUSY_I, BUSY_D};
  - typedef port_t {PORT_INSTR, PORT_DATA};
  - localparam FULL_MASK = 4'hF.
- The watchdog is a natural sub-module, kronos_mem_watchdog: counter, clear, enable, timeout pulse and saturating abort count. The FSM and muxing stay in the top.

Test Plan:
- Single fetch: instr_req=1, addr=0x100, memory acks 3 cycles after mem_req with mem_q=0x00000013 -> mem_addr=0x100, mem_wr_en=0, mem_mask=F; instr_ack one cycle with instr_data=0x13; data_ack stays 0.
- Store: data_req, addr=0x2004, wr_data=0xA5A5A5A5, mask=4'b0011, wr_en=1 -> downstream fields match exactly; data_ack pulses on mem_ack; instr_ack stays 0.
- Tie, ROUND_ROBIN=1, both req held continuously with immediate acks -> grant order D,I,D,I. ROUND_ROBIN=0 -> D every time while data_req is held, instruction starved.
- Timeout, TIMEOUT_CYCLES=8, memory never acks -> data_ack=1, data_rd_data=0xDEADBEEF and bus_error=1 exactly 8 cycles after grant; timeout_count=1; the next request proceeds normally.
- mem_ack coincident with timeout -> normal completion, bus_error=0, timeout_count unchanged.
- Reset asserted in BUSY_I -> no instr_ack, mem_req=0 next cycle, state IDLE. A later mem_ack pulse is ignored.
